// File: rtl/alu_arbiter_if.sv
// Request/response and shared-ALU bundle for alu_arbiter.
// master = requesters plus external ALU, slave = arbiter.
interface alu_arbiter_if #(
  parameter int XLEN = 32,
  parameter int CNTW = 16
);
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [7:0]      req_op;
  logic [2*XLEN-1:0] req_a;
  logic [2*XLEN-1:0] req_b;
  logic [1:0]      resp_valid;
  logic [1:0]      resp_ready;
  logic [XLEN-1:0] resp_data;
  logic [3:0]      alu_op;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [XLEN-1:0] alu_result;
  logic [CNTW-1:0] accept_cnt;

  modport master (
    output req_valid, req_op, req_a, req_b,
    output resp_ready, alu_result,
    input  req_ready, resp_valid, resp_data,
    input  alu_op, alu_a, alu_b, accept_cnt
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b,
    input  resp_ready, alu_result,
    output req_ready, resp_valid, resp_data,
    output alu_op, alu_a, alu_b, accept_cnt
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter for one shared combinational ALU.
// Result is registered and held for its owner until consumed.
module alu_arbiter #(
  parameter int XLEN = 32,
  parameter int CNTW = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  alu_arbiter_if.slave bus
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t          state_q, state_d;
  logic            owner_q;
  logic            prio_q;
  logic [XLEN-1:0] data_q;
  logic [CNTW-1:0] cnt_q;

  logic gnt_vld;
  logic g;
  logic can_accept;
  logic accept;

  // Grant select: single requester wins, tie goes to prio.
  always_comb begin
    gnt_vld = |bus.req_valid;
    g       = 1'b0;
    unique case (1'b1)
      (bus.req_valid == 2'b10): g = 1'b1;
      (bus.req_valid == 2'b11): g = prio_q;
      default:                  g = 1'b0;
    endcase
  end

  // Next state; a held result frees the slot when consumed.
  always_comb begin
    state_d    = state_q;
    can_accept = (state_q == IDLE) ||
                 bus.resp_ready[owner_q];
    accept     = gnt_vld && can_accept;
    if (accept)
      state_d = HOLD;
    else if (state_q == HOLD && bus.resp_ready[owner_q])
      state_d = IDLE;
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Capture result, owner and rotate priority on accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= '0;
      owner_q <= 1'b0;
      prio_q  <= 1'b0;
      cnt_q   <= '0;
    end else if (accept) begin
      data_q  <= bus.alu_result;
      owner_q <= g;
      prio_q  <= ~g;
      cnt_q   <= cnt_q + CNTW'(1);
    end
  end

  assign bus.req_ready  = accept ? {g, ~g} : 2'b00;
  assign bus.alu_op     = !gnt_vld ? 4'h0 :
                          g ? bus.req_op[7:4] :
                              bus.req_op[3:0];
  assign bus.alu_a      = !gnt_vld ? '0 :
                          g ? bus.req_a[2*XLEN-1:XLEN] :
                              bus.req_a[XLEN-1:0];
  assign bus.alu_b      = !gnt_vld ? '0 :
                          g ? bus.req_b[2*XLEN-1:XLEN] :
                              bus.req_b[XLEN-1:0];
  assign bus.resp_valid = (state_q == HOLD) ?
                          {owner_q, ~owner_q} : 2'b00;
  assign bus.resp_data  = data_q;
  assign bus.accept_cnt = cnt_q;

endmodule
